// File: rtl/inst_fetch_arb.sv
// Instruction ROM port arbiter: prefetch FIFO feeding IF/ID plus a data-side read port.
// Optional macro FETCH_PERF_EN adds prefetch-push and stall performance counters.
module inst_fetch_arb #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
`endif
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        if_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    input  logic        dr_req,
    input  logic [31:0] dr_addr,
    output logic        dr_gnt,
    output logic        dr_valid,
    output logic [31:0] dr_data
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALT
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [31:0]      r_fetchPc;
    logic [31:0]      r_pcMem   [FIFO_DEPTH];
    logic [31:0]      r_instMem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W-1:0] r_wrPtr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_ifPc;
    logic [31:0]      r_ifInst;
    logic             r_drValid;
    logic [31:0]      r_drData;

    logic             w_booted;
    logic             w_drGnt;
    logic             w_redir;
    logic             w_ifValid;
    logic             w_pop;
    logic             w_popEff;
    logic             w_push;
    logic [PTR_W-1:0] w_rdPtrNext;
    logic [CNT_W-1:0] w_countAfterPop;
    logic [CNT_W-1:0] w_countNext;
    logic             w_unusedBits;

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_BOOT:  w_stateNext = S_RUN;
            S_RUN:   if (halt) w_stateNext = S_HALT;
            S_HALT:  if (!halt) w_stateNext = S_RUN;
            default: w_stateNext = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_BOOT;
        else     r_state <= w_stateNext;
    end

    assign w_booted  = (r_state != S_BOOT);
    assign w_drGnt   = dr_req && w_booted;
    assign w_redir   = redirect && w_booted;
    assign w_ifValid = (r_count != '0);
    assign w_pop     = w_ifValid && if_ready;
    // A redirect flushes the queue, so a same-cycle pop must not move the read pointer.
    assign w_popEff  = w_pop && !w_redir;
    assign w_push    = (r_state == S_RUN) && !w_drGnt && !redirect
                       && ((r_count < DEPTH_C) || w_pop);

    assign w_rdPtrNext     = r_rdPtr + PTR_W'(w_popEff);
    assign w_countAfterPop = r_count - CNT_W'(w_popEff);
    assign w_countNext     = w_redir ? '0 : (w_countAfterPop + CNT_W'(w_push));
    assign w_unusedBits    = ^{redirect_pc[1:0], dr_addr[1:0]};

    always_comb begin
        rom_ce   = 1'b0;
        rom_addr = 32'h0;
        if (!rst) begin
            if (w_drGnt) begin
                rom_ce   = 1'b1;
                rom_addr = {dr_addr[31:2], 2'b00};
            end else if (w_push) begin
                rom_ce   = 1'b1;
                rom_addr = r_fetchPc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pcMem[r_wrPtr]   <= r_fetchPc;
            r_instMem[r_wrPtr] <= rom_inst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetchPc <= RESET_PC;
            r_rdPtr   <= '0;
            r_wrPtr   <= '0;
            r_count   <= '0;
        end else begin
            r_count <= w_countNext;
            if (w_redir) begin
                r_fetchPc <= {redirect_pc[31:2], 2'b00};
                r_rdPtr   <= '0;
                r_wrPtr   <= '0;
            end else begin
                r_rdPtr <= w_rdPtrNext;
                if (w_push) begin
                    r_fetchPc <= r_fetchPc + 32'd4;
                    r_wrPtr   <= r_wrPtr + PTR_W'(1);
                end
            end
        end
    end

    // The head registers hold their last value whenever the queue ends up empty;
    // an entry pushed into an otherwise-empty queue bypasses storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ifPc   <= 32'h0;
            r_ifInst <= 32'h0;
        end else if (w_countNext != '0) begin
            if (w_countAfterPop == '0) begin
                r_ifPc   <= r_fetchPc;
                r_ifInst <= rom_inst;
            end else begin
                r_ifPc   <= r_pcMem[w_rdPtrNext];
                r_ifInst <= r_instMem[w_rdPtrNext];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drValid <= 1'b0;
            r_drData  <= 32'h0;
        end else begin
            r_drValid <= w_drGnt;
            if (w_drGnt) r_drData <= rom_inst;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perfFetch;
    logic [31:0] r_perfStall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perfFetch <= 32'h0;
            r_perfStall <= 32'h0;
        end else begin
            if (w_push) r_perfFetch <= r_perfFetch + 32'd1;
            if ((r_state == S_RUN) && !w_ifValid) r_perfStall <= r_perfStall + 32'd1;
        end
    end

    assign perf_fetch_cnt = r_perfFetch;
    assign perf_stall_cnt = r_perfStall;
`endif

    assign if_valid = w_ifValid;
    assign if_pc    = r_ifPc;
    assign if_inst  = r_ifInst;
    assign dr_gnt   = w_drGnt;
    assign dr_valid = r_drValid;
    assign dr_data  = r_drData;

endmodule

// File: tb/tb_inst_fetch_arb.sv
// Self-checking bench for inst_fetch_arb: directed vector table, hand-written
// corner sequences and randomized traffic checked against a queue-based model.
module tb_inst_fetch_arb;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        romCe;
   logic [31:0] romAddr;
   logic [31:0] romInst;
   logic        ifValid;
   logic [31:0] ifPc;
   logic [31:0] ifInst;
   logic        ifReady;
   logic        redirect;
   logic [31:0] redirectPc;
   logic        halt;
   logic        drReq;
   logic [31:0] drAddr;
   logic        drGnt;
   logic        drValid;
   logic [31:0] drData;

   logic        wrapRst;
   logic        wrapCe;
   logic [31:0] wrapAddr;
   logic [31:0] wrapInst;
   logic        wrapValid;
   logic [31:0] wrapPc;
   logic [31:0] wrapIfInst;
   logic        wrapGnt;
   logic        wrapDrValid;
   logic [31:0] wrapDrData;

`ifdef FETCH_PERF_EN
   logic [31:0] perfFetch;
   logic [31:0] perfStall;
   logic [31:0] wrapPerfFetch;
   logic [31:0] wrapPerfStall;
`endif

   int assertCount;
   int failCount;

   // ROM contents: word i holds i * 16'h1111, output forced to zero when not enabled.
   function automatic logic [31:0] romWord(input logic [31:0] addr);
      return {15'd0, addr[18:2]} * 32'h1111;
   endfunction

   assign romInst  = romCe ? romWord(romAddr) : 32'h0;
   assign wrapInst = wrapCe ? romWord(wrapAddr) : 32'h0;

   inst_fetch_arb #(.FIFO_DEPTH(DEPTH), .RESET_PC(32'h00000000)) dut (
      .clk(clk),
      .rst(rst),
`ifdef FETCH_PERF_EN
      .perf_fetch_cnt(perfFetch),
      .perf_stall_cnt(perfStall),
`endif
      .rom_ce(romCe),
      .rom_addr(romAddr),
      .rom_inst(romInst),
      .if_valid(ifValid),
      .if_pc(ifPc),
      .if_inst(ifInst),
      .if_ready(ifReady),
      .redirect(redirect),
      .redirect_pc(redirectPc),
      .halt(halt),
      .dr_req(drReq),
      .dr_addr(drAddr),
      .dr_gnt(drGnt),
      .dr_valid(drValid),
      .dr_data(drData)
   );

   inst_fetch_arb #(.FIFO_DEPTH(DEPTH), .RESET_PC(32'hFFFFFFF8)) wrapDut (
      .clk(clk),
      .rst(wrapRst),
`ifdef FETCH_PERF_EN
      .perf_fetch_cnt(wrapPerfFetch),
      .perf_stall_cnt(wrapPerfStall),
`endif
      .rom_ce(wrapCe),
      .rom_addr(wrapAddr),
      .rom_inst(wrapInst),
      .if_valid(wrapValid),
      .if_pc(wrapPc),
      .if_inst(wrapIfInst),
      .if_ready(1'b1),
      .redirect(1'b0),
      .redirect_pc(32'h0),
      .halt(1'b0),
      .dr_req(1'b0),
      .dr_addr(32'h0),
      .dr_gnt(wrapGnt),
      .dr_valid(wrapDrValid),
      .dr_data(wrapDrData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a queue of fetched {pc, inst} pairs plus the fetch pointer.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   entry_t      mQ[$];
   bit          mBooted;
   bit          mHalted;
   logic [31:0] mFetchPc;
   logic [31:0] mLastPc;
   logic [31:0] mLastInst;
   bit          mDrValid;
   logic [31:0] mDrData;

   typedef struct {
      logic        ready;
      logic        redir;
      logic [31:0] redirPc;
      logic        hlt;
      logic        dreq;
      logic [31:0] daddr;
      logic        expCe;
      logic [31:0] expAddr;
      logic        expValid;
      logic [31:0] expPc;
      logic        expDrValid;
   } vec_t;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic modelReset(input logic [31:0] startPc);
      mQ.delete();
      mBooted   = 1'b0;
      mHalted   = 1'b0;
      mFetchPc  = startPc;
      mLastPc   = 32'h0;
      mLastInst = 32'h0;
      mDrValid  = 1'b0;
      mDrData   = 32'h0;
   endtask

   // Compare the DUT against the model for the current cycle, then advance the model one edge.
   task automatic modelCycle();
      bit          eGnt;
      bit          eValid;
      bit          ePop;
      bit          ePf;
      logic        eCe;
      logic [31:0] eAddr;
      eGnt   = drReq && mBooted;
      eValid = (mQ.size() != 0);
      ePop   = eValid && ifReady;
      ePf    = mBooted && !mHalted && !eGnt && !redirect && ((mQ.size() < DEPTH) || ePop);
      eCe    = eGnt || ePf;
      eAddr  = eGnt ? (drAddr & 32'hFFFFFFFC) : (ePf ? mFetchPc : 32'h0);

      checkOutput("rom_ce", {31'd0, romCe}, {31'd0, eCe});
      checkOutput("rom_addr", romAddr, eAddr);
      checkOutput("dr_gnt", {31'd0, drGnt}, {31'd0, eGnt});
      checkOutput("if_valid", {31'd0, ifValid}, {31'd0, eValid});
      checkOutput("if_pc", ifPc, mLastPc);
      checkOutput("if_inst", ifInst, mLastInst);
      checkOutput("dr_valid", {31'd0, drValid}, {31'd0, mDrValid});
      checkOutput("dr_data", drData, mDrData);

      mDrValid = eGnt;
      if (eGnt) mDrData = romWord(drAddr & 32'hFFFFFFFC);
      if (redirect && mBooted) begin
         mQ.delete();
         mFetchPc = redirectPc & 32'hFFFFFFFC;
      end else begin
         if (ePop) void'(mQ.pop_front());
         if (ePf) begin
            mQ.push_back('{pc: mFetchPc, inst: romWord(mFetchPc)});
            mFetchPc = mFetchPc + 32'd4;
         end
      end
      if (mQ.size() != 0) begin
         mLastPc   = mQ[0].pc;
         mLastInst = mQ[0].inst;
      end
      if (!mBooted) begin
         mBooted = 1'b1;
         mHalted = 1'b0;
      end else begin
         mHalted = halt;
      end
   endtask

   task automatic applyStimulus(input logic rdy, input logic red, input logic [31:0] rpc,
                                input logic hlt, input logic dreq, input logic [31:0] daddr);
      @(negedge clk);
      ifReady    = rdy;
      redirect   = red;
      redirectPc = rpc;
      halt       = hlt;
      drReq      = dreq;
      drAddr     = daddr;
      #1;
      modelCycle();
   endtask

   // Hold reset across an edge, check reset values, release just after a rising edge
   // so the next applyStimulus lands on the boot cycle.
   task automatic doReset();
      @(negedge clk);
      rst        = 1'b1;
      ifReady    = 1'b0;
      redirect   = 1'b0;
      redirectPc = 32'h0;
      halt       = 1'b0;
      drReq      = 1'b0;
      drAddr     = 32'h0;
      #1;
      checkOutput("reset rom_ce", {31'd0, romCe}, 32'h0);
      checkOutput("reset if_valid", {31'd0, ifValid}, 32'h0);
      checkOutput("reset if_pc", ifPc, 32'h0);
      checkOutput("reset if_inst", ifInst, 32'h0);
      checkOutput("reset dr_valid", {31'd0, drValid}, 32'h0);
      checkOutput("reset dr_data", drData, 32'h0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      modelReset(32'h00000000);
   endtask

   initial begin
      vec_t        vecs[12];
      logic [31:0] wrapPcs[3];
      bit          haltIn;

      vecs[0]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h0,   1'b0};
      vecs[1]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  1'b1, 32'h0,   1'b0, 32'h0,   1'b0};
      vecs[2]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  1'b1, 32'h4,   1'b1, 32'h0,   1'b0};
      vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  1'b1, 32'h8,   1'b1, 32'h4,   1'b0};
      vecs[4]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  1'b1, 32'hC,   1'b1, 32'h4,   1'b0};
      vecs[5]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  1'b1, 32'h10,  1'b1, 32'h4,   1'b0};
      vecs[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b1, 32'h4,   1'b0};
      vecs[7]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  1'b1, 32'h14,  1'b1, 32'h4,   1'b0};
      vecs[8]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h23, 1'b1, 32'h20,  1'b1, 32'h8,   1'b0};
      vecs[9]  = '{1'b0, 1'b1, 32'h103, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b1, 32'h8,   1'b1};
      vecs[10] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  1'b1, 32'h100, 1'b0, 32'h8,   1'b0};
      vecs[11] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  1'b1, 32'h104, 1'b1, 32'h100, 1'b0};
      wrapPcs  = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000};

      assertCount = 0;
      failCount   = 0;
      wrapRst     = 1'b1;
      rst         = 1'b1;
      doReset();

      // Startup, fill to full, drain one, data read, redirect while full.
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].ready, vecs[i].redir, vecs[i].redirPc, vecs[i].hlt,
                       vecs[i].dreq, vecs[i].daddr);
         checkOutput($sformatf("vec%0d rom_ce", i), {31'd0, romCe}, {31'd0, vecs[i].expCe});
         checkOutput($sformatf("vec%0d rom_addr", i), romAddr, vecs[i].expAddr);
         checkOutput($sformatf("vec%0d if_valid", i), {31'd0, ifValid}, {31'd0, vecs[i].expValid});
         checkOutput($sformatf("vec%0d if_pc", i), ifPc, vecs[i].expPc);
         checkOutput($sformatf("vec%0d dr_valid", i), {31'd0, drValid}, {31'd0, vecs[i].expDrValid});
      end
      checkOutput("redirect target inst", ifInst, 32'h00044440);

      // Three back-to-back data reads alongside fetch.
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h20);
         checkOutput("dr burst gnt", {31'd0, drGnt}, 32'h1);
         checkOutput("dr burst addr", romAddr, 32'h20);
         if (k > 0) begin
            checkOutput("dr burst valid", {31'd0, drValid}, 32'h1);
            checkOutput("dr burst data", drData, 32'h8888);
         end
      end
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("dr last valid", {31'd0, drValid}, 32'h1);
      checkOutput("dr last data", drData, 32'h8888);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("dr pulse end", {31'd0, drValid}, 32'h0);

      // Halt with three queued entries: drain, go idle, resume at the held PC.
      doReset();
      for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOutput("halt drained valid", {31'd0, ifValid}, 32'h0);
      checkOutput("halt drained rom_ce", {31'd0, romCe}, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("resume rom_ce", {31'd0, romCe}, 32'h1);
      checkOutput("resume rom_addr", romAddr, 32'h10);

      // Randomized traffic with occasional mid-run resets.
      for (int blk = 0; blk < 3; blk++) begin
         doReset();
         haltIn = 1'b0;
         for (int c = 0; c < 700; c++) begin
            if ($urandom_range(0, 19) == 0) haltIn = !haltIn;
            applyStimulus(($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 15) == 0),
                          $urandom(),
                          haltIn,
                          ($urandom_range(0, 4) == 0),
                          $urandom());
         end
      end

      // Fetch address wraps from the top of the address space to zero.
      @(posedge clk);
      #2;
      wrapRst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         if (i >= 2) begin
            checkOutput("wrap if_valid", {31'd0, wrapValid}, 32'h1);
            checkOutput("wrap if_pc", wrapPc, wrapPcs[i-2]);
            checkOutput("wrap if_inst", wrapIfInst, romWord(wrapPcs[i-2]));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
